// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
// Imported by the arbiter top and its bench.
package ram_arbiter_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin pick: ties go to the port that
// did not win last time.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    case ({req1, req0})
      2'b11:   gnt = ~last;
      2'b10:   gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer serialising two requesters onto one
// single-port RAM; owns all RAM control pins.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_rst
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_e state_q, state_d;
  logic   winner_q, winner_d;
  logic   last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic   ram_en_q, ram_en_d;
  logic   ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt, gnt_valid;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic grant, rd_last;

  rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  assign sel_we    = gnt ? we1    : we0;
  assign sel_addr  = gnt ? addr1  : addr0;
  assign sel_wdata = gnt ? wdata1 : wdata0;
  assign grant     = (state_q == ST_IDLE) && gnt_valid;
  assign rd_last   = (state_q == ST_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // ram_we_q is still the op type while in ACCESS
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ram_we_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    winner_d   = winner_q;
    last_d     = last_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (grant) begin
      winner_d   = gnt;
      last_d     = gnt;
      ram_en_d   = 1'b1;
      ram_we_d   = sel_we;
      ram_addr_d = sel_addr;
      ram_din_d  = sel_wdata;
    end
    if (rd_last) begin
      if (winner_q) rdata1_d = ram_dout;
      else          rdata0_d = ram_dout;
    end
  end

  always_comb begin
    ack0     = (state_q == ST_DONE) && !winner_q;
    ack1     = (state_q == ST_DONE) &&  winner_q;
    rdata0   = rdata0_q;
    rdata1   = rdata1_q;
    ram_en   = ram_en_q;
    ram_we   = ram_we_q;
    ram_addr = ram_addr_q;
    ram_din  = ram_din_q;
    ram_rst  = rst;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, transaction-level reference,
// directed table, corner sequences and random traffic.
module tb_ram_arbiter #(
  parameter int RD_LAT = 1
);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1;
  logic [9:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [9:0] rdata0, rdata1;
  logic       ram_en, ram_we, ram_rst;
  logic [7:0] ram_addr;
  logic [9:0] ram_din, ram_dout;
  logic       init_ram = 1'b1;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_W(10), .ADDR_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_rst(ram_rst)
  );

  // Block RAM with RD_LAT-deep output pipeline
  logic [9:0] ram_mem [256];
  logic [9:0] ram_pipe [RD_LAT];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
    end else if (ram_en && ram_we) begin
      ram_mem[ram_addr] <= ram_din;
    end
    if (ram_rst) begin
      for (int i = 0; i < RD_LAT; i++) ram_pipe[i] <= '0;
    end else begin
      ram_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr]
                                         : ram_pipe[0];
      for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
  end

  assign ram_dout = ram_pipe[RD_LAT-1];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit ackd0, ackd1;
  int ack_q[$];

  // Transaction-level reference
  bit         m_busy = 0;
  int         m_port, m_grant, m_ack;
  int         m_free = 0;
  int         m_last = 1;
  bit         m_we;
  logic [7:0] m_addr;
  logic [9:0] m_wd, m_rd;
  logic [9:0] m_mem [256];
  logic [9:0] exp_rd [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy    = 0;
      m_free    = cyc + 1;
      m_last    = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      if (m_busy && cyc == m_ack && !m_we) exp_rd[m_port] = m_rd;
      if (cyc >= m_free && (req0 || req1)) begin
        if (req0 && req1) m_port = (m_last == 0) ? 1 : 0;
        else              m_port = req1 ? 1 : 0;
        m_last  = m_port;
        m_busy  = 1;
        m_grant = cyc;
        m_we    = m_port ? we1 : we0;
        m_addr  = m_port ? addr1 : addr0;
        m_wd    = m_port ? wdata1 : wdata0;
        m_ack   = cyc + 1 + (m_we ? 0 : RD_LAT);
        m_free  = m_ack + 2;
        if (m_we) m_mem[m_addr] = m_wd;
        else      m_rd = m_mem[m_addr];
      end
    end
  endtask

  task automatic check_cycle();
    bit e_en, ea0, ea1;
    ea0  = m_busy && cyc == m_ack && m_port == 0;
    ea1  = m_busy && cyc == m_ack && m_port == 1;
    e_en = m_busy && cyc == m_grant;
    chk("ack0", 32'(ack0), 32'(ea0));
    chk("ack1", 32'(ack1), 32'(ea1));
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_we", 32'(ram_we), 32'(e_en && m_we));
    if (e_en) chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    if (e_en && m_we) chk("ram_din", 32'(ram_din), 32'(m_wd));
    chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
    chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
    chk("ram_rst", 32'(ram_rst), 32'(rst));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    if (chk_en) check_cycle();
    ackd0 = ack0;
    ackd1 = ack1;
    if (ack0) begin req0 = 0; ack_q.push_back(0); end
    if (ack1) begin req1 = 0; ack_q.push_back(1); end
  endtask

  task automatic issue(input int p, input bit w, input logic [7:0] a,
                       input logic [9:0] d);
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req0 || req1) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(req0 | req1), 32'd0);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (!ram_en && n < budget) begin
      tick();
      n++;
    end
    chk("grant_timeout", 32'(ram_en), 32'd1);
  endtask

  typedef struct {
    bit r0; bit w0; logic [7:0] a0; logic [9:0] d0;
    bit r1; bit w1; logic [7:0] a1; logic [9:0] d1;
    int first; logic [9:0] e0; logic [9:0] e1;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    bit got1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    vt[0] = '{1,1,8'h12,10'h2AB, 0,0,8'h00,10'h000, 0, 10'h000,10'h000};
    vt[1] = '{1,0,8'h12,10'h000, 0,0,8'h00,10'h000, 0, 10'h2AB,10'h000};
    vt[2] = '{1,1,8'h00,10'h000, 0,0,8'h00,10'h000, 0, 10'h2AB,10'h000};
    vt[3] = '{0,0,8'h00,10'h000, 1,1,8'hFF,10'h3FF, 1, 10'h2AB,10'h000};
    vt[4] = '{1,0,8'hFF,10'h000, 1,0,8'h12,10'h000, 0, 10'h3FF,10'h2AB};
    vt[5] = '{1,0,8'h12,10'h000, 0,0,8'h00,10'h000, 0, 10'h2AB,10'h2AB};
    vt[6] = '{1,0,8'h00,10'h000, 1,0,8'hFF,10'h000, 1, 10'h000,10'h3FF};

    tick();
    chk_en = 1;
    tick();
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_ram_rst", 32'(ram_rst), 32'd1);
    rst = 0;
    init_ram = 0;
    tick();

    for (int i = 0; i < 7; i++) begin
      ack_q.delete();
      if (vt[i].r0) issue(0, vt[i].w0, vt[i].a0, vt[i].d0);
      if (vt[i].r1) issue(1, vt[i].w1, vt[i].a1, vt[i].d1);
      drain(40);
      chk($sformatf("v%0d_first", i),
          ack_q.size() > 0 ? 32'(ack_q[0]) : 32'd9, 32'(vt[i].first));
      chk($sformatf("v%0d_rdata0", i), 32'(rdata0), 32'(vt[i].e0));
      chk($sformatf("v%0d_rdata1", i), 32'(rdata1), 32'(vt[i].e1));
    end

    // reset while a read sits in WAIT
    issue(1, 0, 8'hFF, 10'h000);
    wait_en(10);
    tick();
    rst = 1;
    tick();
    chk("abort_ack1", 32'(ack1), 32'd0);
    rst = 0;
    tick();
    chk("regrant_en", 32'(ram_en), 32'd1);
    drain(40);
    chk("abort_rdata1", 32'(rdata1), 32'h3FF);

    // reset on the ACCESS edge of a write still commits it
    issue(0, 1, 8'h40, 10'h1C3);
    wait_en(10);
    rst = 1;
    req0 = 0;
    tick();
    rst = 0;
    tick();
    issue(1, 0, 8'h40, 10'h000);
    drain(40);
    chk("rst_write_commit", 32'(rdata1), 32'h1C3);

    // port 0 hammers, port 1 asks once
    issue(1, 0, 8'h12, 10'h000);
    issue(0, 1, 8'h20, 10'h011);
    n0 = 0;
    got1 = 0;
    n = 0;
    while (!got1 && n < 60) begin
      tick();
      n++;
      if (ackd0) n0++;
      if (ackd1) got1 = 1;
      if (!req0 && !got1)
        issue(0, 1, 8'h20 + 8'($urandom_range(0, 15)), 10'($urandom));
    end
    chk("starve_served", 32'(got1), 32'd1);
    chk("starve_bound", 32'(n0 <= 1), 32'd1);
    drain(40);

    // random traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!req0 && !ackd0 && $urandom_range(0, 2) == 0)
        issue(0, 1'($urandom), {$urandom_range(0, 1) ? 5'h1F : 5'h00,
              3'($urandom)}, 10'($urandom));
      if (!req1 && !ackd1 && $urandom_range(0, 2) == 0)
        issue(1, 1'($urandom), {$urandom_range(0, 1) ? 5'h1F : 5'h00,
              3'($urandom)}, 10'($urandom));
      tick();
    end
    rst = 0;
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
